// File: rtl/multi_range_finder.sv
// Per-channel running max/min/range/count over a go/finish-delimited frame.
// Statistics update one edge after an accepted sample; readback is combinational from registers.
module multi_range_finder #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int SIGNED    = 0,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    input  logic                 finish,
    input  logic                 data_valid,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [CW-1:0]        chan_sel,
    input  logic [CW-1:0]        rd_chan,
    output logic [WIDTH-1:0]     rd_max,
    output logic [WIDTH-1:0]     rd_min,
    output logic [WIDTH-1:0]     rd_range,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic                 rd_valid,
    output logic                 sat,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [1:0] {IDLE, RECEIVING, DONE, ERROR} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t state_q, state_d;

    logic [WIDTH-1:0]     max_q [CHANNELS];
    logic [WIDTH-1:0]     min_q [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
    logic                 sat_q;

    logic frame_start;
    logic accept;

    function automatic logic is_less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) < $signed(b);
        else             return a < b;
    endfunction

    // go together with finish is an error and must not disturb any statistic.
    assign frame_start = go && !finish;
    assign accept      = data_valid && !(go && finish)
                         && (go || state_q == RECEIVING)
                         && (int'(chan_sel) < CHANNELS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        error   = 1'b0;
        if (go && finish)  state_d = ERROR;
        else if (go)       state_d = RECEIVING;
        else if (finish)   state_d = (state_q == RECEIVING) ? DONE : ERROR;
        case (state_q)
            RECEIVING: busy  = 1'b1;
            DONE:      done  = 1'b1;
            ERROR:     error = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sat_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                max_q[c] <= '0;
                min_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            if (frame_start) sat_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (frame_start) cnt_q[c] <= '0;
                if (accept && int'(chan_sel) == c) begin
                    // The first sample of a channel in a frame seeds both extremes.
                    if (frame_start || cnt_q[c] == '0 || is_less(max_q[c], data_in))
                        max_q[c] <= data_in;
                    if (frame_start || cnt_q[c] == '0 || is_less(data_in, min_q[c]))
                        min_q[c] <= data_in;
                    if (frame_start)
                        cnt_q[c] <= CNT_ONE;
                    else if (cnt_q[c] == CNT_MAX)
                        sat_q <= 1'b1;
                    else
                        cnt_q[c] <= cnt_q[c] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_max   = '0;
        rd_min   = '0;
        rd_count = '0;
        if (int'(rd_chan) < CHANNELS) begin
            rd_max   = max_q[rd_chan];
            rd_min   = min_q[rd_chan];
            rd_count = cnt_q[rd_chan];
        end
        rd_range = rd_max - rd_min;
        rd_valid = (rd_count != '0);
        sat      = sat_q;
    end

endmodule

// File: tb/tb_multi_range_finder.sv
// Bench for multi_range_finder: default, signed and narrow-counter instances share one stimulus bus.
module tb_multi_range_finder;

    logic        clock;
    logic        reset;
    logic        go, finish, data_valid;
    logic [15:0] data_in;
    logic [1:0]  chan_sel, rd_chan;

    logic [15:0] rd_max, rd_min, rd_range;
    logic [7:0]  rd_count;
    logic        rd_valid, sat, busy, done, error;

    logic [15:0] s_max, s_min, s_range;
    logic [7:0]  s_count;
    logic        s_valid, s_sat, s_busy, s_done, s_error;

    logic [15:0] c_max, c_min, c_range;
    logic [1:0]  c_count;
    logic        c_valid, c_sat, c_busy, c_done, c_error;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [1:0]  ch;
        logic [15:0] mx, mn, rg;
        logic [7:0]  cnt;
        logic        vld;
    } exp_t;
    exp_t sbq[$];

    multi_range_finder dut (
        .clock(clock), .reset(reset), .go(go), .finish(finish), .data_valid(data_valid),
        .data_in(data_in), .chan_sel(chan_sel), .rd_chan(rd_chan),
        .rd_max(rd_max), .rd_min(rd_min), .rd_range(rd_range), .rd_count(rd_count),
        .rd_valid(rd_valid), .sat(sat), .busy(busy), .done(done), .error(error));

    multi_range_finder #(.SIGNED(1)) dut_s (
        .clock(clock), .reset(reset), .go(go), .finish(finish), .data_valid(data_valid),
        .data_in(data_in), .chan_sel(chan_sel), .rd_chan(rd_chan),
        .rd_max(s_max), .rd_min(s_min), .rd_range(s_range), .rd_count(s_count),
        .rd_valid(s_valid), .sat(s_sat), .busy(s_busy), .done(s_done), .error(s_error));

    multi_range_finder #(.CNT_WIDTH(2)) dut_c (
        .clock(clock), .reset(reset), .go(go), .finish(finish), .data_valid(data_valid),
        .data_in(data_in), .chan_sel(chan_sel), .rd_chan(rd_chan),
        .rd_max(c_max), .rd_min(c_min), .rd_range(c_range), .rd_count(c_count),
        .rd_valid(c_valid), .sat(c_sat), .busy(c_busy), .done(c_done), .error(c_error));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input logic g, input logic f, input logic v,
                        input logic [15:0] d, input logic [1:0] c);
        go = g; finish = f; data_valid = v; data_in = d; chan_sel = c;
        @(posedge clock); #1;
        go = 1'b0; finish = 1'b0; data_valid = 1'b0;
    endtask

    task automatic push_exp(input string name, input logic [1:0] ch, input logic [15:0] mx,
                            input logic [15:0] mn, input logic [15:0] rg,
                            input logic [7:0] cnt, input logic vld);
        exp_t e;
        e.name = name; e.ch = ch; e.mx = mx; e.mn = mn; e.rg = rg; e.cnt = cnt; e.vld = vld;
        sbq.push_back(e);
    endtask

    // Pops every pending expectation and compares the default instance's readback.
    task automatic drain_scoreboard();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rd_chan = e.ch;
            #1;
            n_cmp++;
            if (rd_max !== e.mx) begin
                n_err++; $display("FAIL %s.max: got %h want %h", e.name, rd_max, e.mx);
            end
            n_cmp++;
            if (rd_min !== e.mn) begin
                n_err++; $display("FAIL %s.min: got %h want %h", e.name, rd_min, e.mn);
            end
            n_cmp++;
            if (rd_range !== e.rg) begin
                n_err++; $display("FAIL %s.range: got %h want %h", e.name, rd_range, e.rg);
            end
            n_cmp++;
            if (rd_count !== e.cnt) begin
                n_err++; $display("FAIL %s.count: got %0d want %0d", e.name, rd_count, e.cnt);
            end
            n_cmp++;
            if (rd_valid !== e.vld) begin
                n_err++; $display("FAIL %s.valid: got %b want %b", e.name, rd_valid, e.vld);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go = 1'b0; finish = 1'b0; data_valid = 1'b0; data_in = '0; chan_sel = '0; rd_chan = '0;
        #12;
        n_cmp++;
        if ({busy, done, error, sat, rd_valid} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 00000", {busy, done, error, sat, rd_valid});
        end
        n_cmp++;
        if ({rd_max, rd_min, rd_range, rd_count} !== 56'b0) begin
            n_err++; $display("FAIL reset_stats: got %h want 0", {rd_max, rd_min, rd_range, rd_count});
        end
        reset = 1'b0;
        #4;
    endtask

    task automatic test_basic();
        step(1, 0, 1, 16'd5, 2'd0);
        step(0, 0, 1, 16'd9, 2'd0);
        step(0, 1, 1, 16'd2, 2'd0);
        n_cmp++;
        if ({busy, done, error} !== 3'b010) begin
            n_err++; $display("FAIL basic_flags: got %b want 010", {busy, done, error});
        end
        push_exp("basic_ch0", 2'd0, 16'd9, 16'd2, 16'd7, 8'd3, 1'b1);
        push_exp("basic_ch1", 2'd1, 16'd0, 16'd0, 16'd0, 8'd0, 1'b0);
        drain_scoreboard();
    endtask

    task automatic test_interleave();
        step(1, 0, 0, 16'd0, 2'd0);
        step(0, 0, 1, 16'd100, 2'd1);
        step(0, 0, 1, 16'd40, 2'd2);
        step(0, 0, 1, 16'd30, 2'd1);
        step(0, 0, 1, 16'd60, 2'd2);
        step(0, 1, 0, 16'd0, 2'd0);
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++; $display("FAIL interleave_done: got %b want 1", done);
        end
        push_exp("ilv_ch1", 2'd1, 16'd100, 16'd30, 16'd70, 8'd2, 1'b1);
        push_exp("ilv_ch2", 2'd2, 16'd60, 16'd40, 16'd20, 8'd2, 1'b1);
        push_exp("ilv_ch0_stale", 2'd0, 16'd9, 16'd2, 16'd7, 8'd0, 1'b0);
        drain_scoreboard();
    endtask

    task automatic test_signed();
        step(1, 0, 1, 16'hFFFE, 2'd0);
        step(0, 1, 1, 16'h0003, 2'd0);
        rd_chan = 2'd0;
        #1;
        n_cmp++;
        if ({s_max, s_min, s_range} !== {16'h0003, 16'hFFFE, 16'h0005}) begin
            n_err++; $display("FAIL signed_stats: got %h/%h/%h want 0003/fffe/0005", s_max, s_min, s_range);
        end
        push_exp("unsigned_ch0", 2'd0, 16'hFFFE, 16'h0003, 16'hFFFB, 8'd2, 1'b1);
        drain_scoreboard();
    endtask

    task automatic test_error();
        step(1, 0, 1, 16'd7, 2'd0);
        step(0, 0, 1, 16'd8, 2'd0);
        step(1, 1, 1, 16'd100, 2'd0);
        n_cmp++;
        if ({busy, done, error} !== 3'b001) begin
            n_err++; $display("FAIL err_gofin: got %b want 001", {busy, done, error});
        end
        push_exp("err_hold", 2'd0, 16'd8, 16'd7, 16'd1, 8'd2, 1'b1);
        drain_scoreboard();
        step(0, 1, 1, 16'd200, 2'd0);
        n_cmp++;
        if (error !== 1'b1) begin
            n_err++; $display("FAIL err_finish_stays: got %b want 1", error);
        end
        push_exp("err_ignored_sample", 2'd0, 16'd8, 16'd7, 16'd1, 8'd2, 1'b1);
        drain_scoreboard();
        step(1, 0, 1, 16'd7, 2'd0);
        n_cmp++;
        if ({busy, done, error} !== 3'b100) begin
            n_err++; $display("FAIL err_recover: got %b want 100", {busy, done, error});
        end
        push_exp("err_restart", 2'd0, 16'd7, 16'd7, 16'd0, 8'd1, 1'b1);
        drain_scoreboard();
    endtask

    task automatic test_saturate();
        logic [15:0] vals [5];
        vals = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
        rd_chan = 2'd3;
        for (int i = 0; i < 5; i++) begin
            step(i == 0, 0, 1, vals[i], 2'd3);
            if (i == 1) begin
                n_cmp++;
                if ({c_count, c_sat} !== {2'd2, 1'b0}) begin
                    n_err++; $display("FAIL sat_early: got cnt %0d sat %b want cnt 2 sat 0", c_count, c_sat);
                end
            end
        end
        n_cmp++;
        if ({c_count, c_sat} !== {2'd3, 1'b1}) begin
            n_err++; $display("FAIL sat_full: got cnt %0d sat %b want cnt 3 sat 1", c_count, c_sat);
        end
        n_cmp++;
        if (sat !== 1'b0) begin
            n_err++; $display("FAIL sat_wide_clear: got %b want 0", sat);
        end
        push_exp("sat_wide_ch3", 2'd3, 16'd50, 16'd10, 16'd40, 8'd5, 1'b1);
        drain_scoreboard();
        rd_chan = 2'd3;
        step(1, 0, 1, 16'd77, 2'd3);
        n_cmp++;
        if ({c_count, c_sat, c_busy} !== {2'd1, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL sat_restart: got cnt %0d sat %b busy %b want 1 0 1", c_count, c_sat, c_busy);
        end
        push_exp("restart_ch3", 2'd3, 16'd77, 16'd77, 16'd0, 8'd1, 1'b1);
        drain_scoreboard();
    endtask

    task automatic test_reset_mid();
        step(1, 0, 1, 16'd11, 2'd0);
        step(0, 0, 1, 16'd22, 2'd0);
        rd_chan = 2'd0;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({rd_max, rd_min, rd_range, rd_count, rd_valid, sat, busy, done, error} !== 61'b0) begin
            n_err++; $display("FAIL mid_reset: got %h want 0",
                              {rd_max, rd_min, rd_range, rd_count, rd_valid, sat, busy, done, error});
        end
        #2;
        reset = 1'b0;
        step(0, 1, 0, 16'd0, 2'd0);
        n_cmp++;
        if ({busy, done, error} !== 3'b001) begin
            n_err++; $display("FAIL idle_finish: got %b want 001", {busy, done, error});
        end
        step(1, 0, 1, 16'd33, 2'd1);
        push_exp("clean_ch0", 2'd0, 16'd0, 16'd0, 16'd0, 8'd0, 1'b0);
        push_exp("clean_ch1", 2'd1, 16'd33, 16'd33, 16'd0, 8'd1, 1'b1);
        drain_scoreboard();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_interleave();
        test_signed();
        test_error();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_range_finder.md
# multi_range_finder

Parametrised, multi-channel successor to the single-stream range finder. It tracks running max, min, range and sample count for up to CHANNELS interleaved sample streams within one go/finish-delimited frame. Signed or unsigned comparison is selectable, and the counter saturates. Final per-channel statistics are held for readback after the frame ends. It sits between the sample front-end and the status/readout logic.

## Interface
- WIDTH, 16, sample width in bits
- CHANNELS, 4, number of independent channels (≥1)
- CW, $clog2(CHANNELS) (min 1), channel index width
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned
- CNT_WIDTH, 8, per-channel sample counter width
- clock  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, asynchronous, active-high
- go  in  1  start a new frame
- finish  in  1  end the current frame
- data_valid  in  1  data_in/chan_sel carry a sample this cycle
- data_in  in  WIDTH  sample value
- chan_sel  in  CW  channel the sample belongs to
- rd_chan  in  CW  channel selected for readback
- rd_max  out  WIDTH  stored max of rd_chan
- rd_min  out  WIDTH  stored min of rd_chan
- rd_range  out  WIDTH  rd_max − rd_min, unsigned, modulo 2^WIDTH
- rd_count  out  CNT_WIDTH  samples accepted on rd_chan this frame (saturating)
- rd_valid  out  1  rd_count ≠ 0
- sat  out  1  sticky: some channel's counter saturated this frame
- busy  out  1  state == RECEIVING
- done  out  1  state == DONE
- error  out  1  state == ERROR

## Operation
- Reset clears state to IDLE and every max, min, count and sat to 0. All outputs read 0.
- FSM has four states: IDLE, RECEIVING, DONE, ERROR.
  - Any state, go & finish → ERROR. No statistics change.
  - IDLE/DONE/ERROR, go & ~finish → RECEIVING. The frame starts.
  - IDLE/DONE, finish & ~go → ERROR.
  - ERROR, finish & ~go → stays in ERROR. With neither go nor finish, each state holds.
  - RECEIVING, go & ~finish → stays in RECEIVING and the frame restarts (new behaviour: restart without error).
  - RECEIVING, finish & ~go → DONE.
- Frame start (any accepted go without finish):
  - All channels' counts and sat clear in the same edge.
  - A data_valid sample on the go cycle is the first sample of the new frame.
- Sample acceptance: data_valid is honoured only on cycles that are either in RECEIVING or are frame-start cycles. This includes the finish cycle, so the last sample is included.
  - data_valid in IDLE/DONE/ERROR without go is ignored.
  - A sample with chan_sel ≥ CHANNELS is ignored.
- Per-channel update for an accepted sample on channel c:
  - If count[c] == 0 (or this is the frame-start cycle), max[c] and min[c] both load data_in.
  - Otherwise max[c] updates if data_in > max[c], and min[c] updates if data_in < min[c].
  - Compares are signed when SIGNED = 1.
  - count[c] increments. At 2^CNT_WIDTH−1 it holds, and sat sets.
- Channels not sampled in a frame keep count 0. Their max/min read as the stale previous values, and rd_valid = 0 marks them invalid.
- Readback is combinational from registers only, with no bypass of the in-flight sample.
  - rd_range = max − min in WIDTH bits. It is correct as an unsigned magnitude for both modes, e.g. SIGNED, 16 bit: max 0x7FFF, min 0x8000 → 0xFFFF.
  - rd_chan ≥ CHANNELS reads all zeros.
- Statistics are retained through DONE and ERROR until the next frame start or reset.

## Timing
- A sample accepted at edge t is reflected in rd_* after edge t; it is visible in cycle t+1.
- go/finish state changes take effect at the same edge; busy/done/error are registered-state decodes.
- done asserts the cycle after finish is accepted and stays high until go or an error.
- Zero-latency readback: rd_* follow rd_chan combinationally.
- Asynchronous reset mid-frame immediately forces IDLE and zero outputs. The next go starts a clean frame.

## Test plan
- Reset, then go with sample ch0 = 5, then ch0 = 9, then ch0 = 2 with finish → done = 1; rd_chan 0 gives max 9, min 2, range 7, count 3; ch1 rd_valid = 0.
- Interleaved: ch1 = 100, ch2 = 40, ch1 = 30, ch2 = 60, finish → ch1 range 70, count 2; ch2 range 20, count 2.
- SIGNED = 1: ch0 samples 0xFFFE (−2), 0x0003 → max 0x0003, min 0xFFFE, range 5. The same samples with SIGNED = 0 give range 0xFFFB.
- go & finish together from RECEIVING → error = 1 next cycle with stats unchanged. finish alone in ERROR keeps error. Then go with ch0 = 7 → busy, count 1, max = min = 7.
- CNT_WIDTH = 2: five valid samples on ch3 → count 3, sat = 1. A mid-frame go clears count and sat, and the go-cycle sample gives count 1.
- Reset asserted mid-frame after 2 samples → all rd_* and flags 0 immediately. finish in IDLE → error.
